// File: rtl/branch_pkg.sv
// Shared types for the branch unit: funct3 encodings, request kinds and FSM states.
package branch_pkg;

  localparam logic [2:0] F3_BEQ  = 3'b000;
  localparam logic [2:0] F3_BNE  = 3'b001;
  localparam logic [2:0] F3_BLT  = 3'b100;
  localparam logic [2:0] F3_BGE  = 3'b101;
  localparam logic [2:0] F3_BLTU = 3'b110;
  localparam logic [2:0] F3_BGEU = 3'b111;

  typedef enum logic [1:0] {
    KIND_BR   = 2'd0,
    KIND_JAL  = 2'd1,
    KIND_JALR = 2'd2,
    KIND_RSVD = 2'd3
  } kind_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_EVAL = 2'd1,
    ST_RESP = 2'd2
  } state_e;

endpackage

// File: rtl/branch_unit_if.sv
// Request/response handshake bundle between decode, the branch unit and PC-select.
// master = decode/PC-select side, slave = branch_unit.
interface branch_unit_if #(
  parameter int XLEN = 32
);
  logic            req_valid;
  logic            req_ready;
  logic [1:0]      req_kind;
  logic [2:0]      req_funct3;
  logic [XLEN-1:0] req_pc;
  logic [XLEN-1:0] req_imm;
  logic [XLEN-1:0] req_rs1;
  logic [XLEN-1:0] req_rs2;
  logic            req_pred_taken;

  logic            resp_valid;
  logic            resp_ready;
  logic            resp_pc_sel;
  logic [XLEN-1:0] resp_target;
  logic [XLEN-1:0] resp_link;
  logic            resp_mispredict;
  logic            resp_illegal;
  logic            resp_misalign;

  modport master (
    output req_valid, req_kind, req_funct3, req_pc, req_imm, req_rs1, req_rs2,
           req_pred_taken, resp_ready,
    input  req_ready, resp_valid, resp_pc_sel, resp_target, resp_link,
           resp_mispredict, resp_illegal, resp_misalign
  );

  modport slave (
    input  req_valid, req_kind, req_funct3, req_pc, req_imm, req_rs1, req_rs2,
           req_pred_taken, resp_ready,
    output req_ready, resp_valid, resp_pc_sel, resp_target, resp_link,
           resp_mispredict, resp_illegal, resp_misalign
  );
endinterface

// File: rtl/branch_cond.sv
// Branch condition decode: funct3 plus comparator flags -> taken / illegal.
module branch_cond
  import branch_pkg::*;
(
  input  logic [2:0] funct3,
  input  logic       less,
  input  logic       equal,
  output logic       taken,
  output logic       illegal
);

  always_comb begin
    taken   = 1'b0;
    illegal = 1'b0;
    case (funct3)
      F3_BEQ:          taken = equal;
      F3_BNE:          taken = !equal;
      F3_BLT, F3_BLTU: taken = less;
      F3_BGE, F3_BGEU: taken = !less;
      default:         illegal = 1'b1;
    endcase
  end

endmodule

// File: rtl/branch_unit.sv
// Branch/jump resolver: drives the external comparator for one EVAL cycle, then holds the result.
// Optional saturating statistics counters are built when BRU_PERF_CNT_EN is defined.
module branch_unit
  import branch_pkg::*;
#(
  parameter int XLEN         = 32,
  parameter bit RESET_PC_SEL = 1'b0
) (
  input  logic            clk,
  input  logic            rst,
  branch_unit_if.slave    bus,
  output logic [XLEN-1:0] rs1_data,
  output logic [XLEN-1:0] rs2_data,
  output logic            br_un,
  input  logic            br_less,
  input  logic            br_equal,
  output logic [31:0]     perf_branches,
  output logic [31:0]     perf_taken,
  output logic [31:0]     perf_mispred
);

  state_e          state_q, state_d;
  kind_e           kind_q, kind_d;
  logic [2:0]      funct3_q, funct3_d;
  logic [XLEN-1:0] pc_q, pc_d, imm_q, imm_d, rs1_q, rs1_d, rs2_q, rs2_d;
  logic            pred_q, pred_d, br_un_q, br_un_d;
  logic            pc_sel_q, pc_sel_d, mispredict_q, mispredict_d;
  logic            illegal_q, illegal_d, misalign_q, misalign_d;
  logic [XLEN-1:0] target_q, target_d, link_q, link_d;

  logic            cond_taken, cond_illegal;
  logic            eval_taken, eval_illegal, eval_misalign, eval_pc_sel;
  logic [XLEN-1:0] eval_target, jalr_sum;

  branch_cond u_cond (
    .funct3  (funct3_q),
    .less    (br_less),
    .equal   (br_equal),
    .taken   (cond_taken),
    .illegal (cond_illegal)
  );

  always_comb begin
    eval_taken   = 1'b0;
    eval_illegal = 1'b0;
    case (kind_q)
      KIND_BR: begin
        eval_taken   = cond_taken;
        eval_illegal = cond_illegal;
      end
      KIND_JAL, KIND_JALR: eval_taken = 1'b1;
      default:             eval_illegal = 1'b1;
    endcase
    jalr_sum      = rs1_q + imm_q;
    eval_target   = (kind_q == KIND_JALR) ? {jalr_sum[XLEN-1:1], 1'b0} : pc_q + imm_q;
    eval_misalign = eval_taken && (eval_target[1:0] != 2'b00);
    eval_pc_sel   = eval_taken && !eval_misalign;
  end

  always_comb begin
    state_d      = state_q;
    kind_d       = kind_q;
    funct3_d     = funct3_q;
    pc_d         = pc_q;
    imm_d        = imm_q;
    rs1_d        = rs1_q;
    rs2_d        = rs2_q;
    pred_d       = pred_q;
    br_un_d      = br_un_q;
    pc_sel_d     = pc_sel_q;
    target_d     = target_q;
    link_d       = link_q;
    mispredict_d = mispredict_q;
    illegal_d    = illegal_q;
    misalign_d   = misalign_q;
    case (state_q)
      ST_IDLE: if (bus.req_valid) begin
        kind_d   = kind_e'(bus.req_kind);
        funct3_d = bus.req_funct3;
        pc_d     = bus.req_pc;
        imm_d    = bus.req_imm;
        rs1_d    = bus.req_rs1;
        rs2_d    = bus.req_rs2;
        pred_d   = bus.req_pred_taken;
        br_un_d  = (bus.req_kind == KIND_BR) ? bus.req_funct3[1] : 1'b0;
        state_d  = ST_EVAL;
      end
      ST_EVAL: begin
        pc_sel_d     = eval_pc_sel;
        target_d     = eval_target;
        link_d       = pc_q + XLEN'(4);
        misalign_d   = eval_misalign;
        illegal_d    = eval_illegal;
        mispredict_d = !eval_illegal && (eval_pc_sel != pred_q);
        state_d      = ST_RESP;
      end
      ST_RESP: if (bus.resp_ready) state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= ST_IDLE;
      kind_q       <= KIND_BR;
      funct3_q     <= '0;
      pc_q         <= '0;
      imm_q        <= '0;
      rs1_q        <= '0;
      rs2_q        <= '0;
      pred_q       <= 1'b0;
      br_un_q      <= 1'b0;
      pc_sel_q     <= RESET_PC_SEL;
      target_q     <= '0;
      link_q       <= '0;
      mispredict_q <= 1'b0;
      illegal_q    <= 1'b0;
      misalign_q   <= 1'b0;
    end else begin
      state_q      <= state_d;
      kind_q       <= kind_d;
      funct3_q     <= funct3_d;
      pc_q         <= pc_d;
      imm_q        <= imm_d;
      rs1_q        <= rs1_d;
      rs2_q        <= rs2_d;
      pred_q       <= pred_d;
      br_un_q      <= br_un_d;
      pc_sel_q     <= pc_sel_d;
      target_q     <= target_d;
      link_q       <= link_d;
      mispredict_q <= mispredict_d;
      illegal_q    <= illegal_d;
      misalign_q   <= misalign_d;
    end
  end

  // Comparator operands come straight from the latched request so they are stable through EVAL.
  assign rs1_data            = rs1_q;
  assign rs2_data            = rs2_q;
  assign br_un               = br_un_q;
  assign bus.req_ready       = (state_q == ST_IDLE);
  assign bus.resp_valid      = (state_q == ST_RESP);
  assign bus.resp_pc_sel     = pc_sel_q;
  assign bus.resp_target     = target_q;
  assign bus.resp_link       = link_q;
  assign bus.resp_mispredict = mispredict_q;
  assign bus.resp_illegal    = illegal_q;
  assign bus.resp_misalign   = misalign_q;

`ifdef BRU_PERF_CNT_EN
  logic [31:0] perf_branches_q, perf_branches_d;
  logic [31:0] perf_taken_q, perf_taken_d;
  logic [31:0] perf_mispred_q, perf_mispred_d;
  logic        resp_fire;

  assign resp_fire = (state_q == ST_RESP) && bus.resp_ready;

  always_comb begin
    perf_branches_d = perf_branches_q;
    perf_taken_d    = perf_taken_q;
    perf_mispred_d  = perf_mispred_q;
    if (resp_fire) begin
      if (kind_q == KIND_BR && !illegal_q && perf_branches_q != 32'hFFFF_FFFF)
        perf_branches_d = perf_branches_q + 32'd1;
      if (pc_sel_q && perf_taken_q != 32'hFFFF_FFFF)
        perf_taken_d = perf_taken_q + 32'd1;
      if (mispredict_q && perf_mispred_q != 32'hFFFF_FFFF)
        perf_mispred_d = perf_mispred_q + 32'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      perf_branches_q <= '0;
      perf_taken_q    <= '0;
      perf_mispred_q  <= '0;
    end else begin
      perf_branches_q <= perf_branches_d;
      perf_taken_q    <= perf_taken_d;
      perf_mispred_q  <= perf_mispred_d;
    end
  end

  assign perf_branches = perf_branches_q;
  assign perf_taken    = perf_taken_q;
  assign perf_mispred  = perf_mispred_q;
`else
  assign perf_branches = '0;
  assign perf_taken    = '0;
  assign perf_mispred  = '0;
`endif

endmodule

// File: tb/tb_branch_unit.sv
// Directed bench for branch_unit with a behavioural comparator model and hand-computed expectations.
module tb_branch_unit;
  import branch_pkg::*;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [31:0] rs1_data, rs2_data;
  logic        br_un, br_less, br_equal;
  logic [31:0] perf_branches, perf_taken, perf_mispred;

  int tests_run    = 0;
  int tests_failed = 0;
  int lat;
  logic eval_br_un;

  always #5 clk = ~clk;

  branch_unit_if #(.XLEN(32)) bus ();

  branch_unit #(.XLEN(32), .RESET_PC_SEL(1'b0)) dut (
    .clk           (clk),
    .rst           (rst),
    .bus           (bus),
    .rs1_data      (rs1_data),
    .rs2_data      (rs2_data),
    .br_un         (br_un),
    .br_less       (br_less),
    .br_equal      (br_equal),
    .perf_branches (perf_branches),
    .perf_taken    (perf_taken),
    .perf_mispred  (perf_mispred)
  );

  // External comparator
  assign br_equal = (rs1_data == rs2_data);
  assign br_less  = br_un ? (rs1_data < rs2_data) : ($signed(rs1_data) < $signed(rs2_data));

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests_run++;
    if (got !== exp) begin
      tests_failed++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  task automatic launch(input logic [1:0] kind, input logic [2:0] f3, input logic [31:0] pc,
                        input logic [31:0] imm, input logic [31:0] rs1, input logic [31:0] rs2,
                        input logic pred);
    @(negedge clk);
    bus.req_kind       = kind;
    bus.req_funct3     = f3;
    bus.req_pc         = pc;
    bus.req_imm        = imm;
    bus.req_rs1        = rs1;
    bus.req_rs2        = rs2;
    bus.req_pred_taken = pred;
    bus.req_valid      = 1'b1;
    @(posedge clk);
    #1;
    bus.req_valid = 1'b0;
    eval_br_un    = br_un;
  endtask

  task automatic send(input logic [1:0] kind, input logic [2:0] f3, input logic [31:0] pc,
                      input logic [31:0] imm, input logic [31:0] rs1, input logic [31:0] rs2,
                      input logic pred);
    launch(kind, f3, pc, imm, rs1, rs2, pred);
    lat = 1;
    while (!bus.resp_valid && lat < 10) begin
      @(posedge clk);
      #1;
      lat++;
    end
    check_val("latency", lat, 32'd2);
    $display("[TB] txn kind=%0d f3=%0d pc=%08h -> pc_sel=%0d target=%08h link=%08h mp=%0d ill=%0d mis=%0d",
             kind, f3, pc, bus.resp_pc_sel, bus.resp_target, bus.resp_link,
             bus.resp_mispredict, bus.resp_illegal, bus.resp_misalign);
  endtask

  task automatic expect_resp(input string tag, input logic pc_sel, input logic [31:0] target,
                             input logic [31:0] link, input logic mp, input logic ill,
                             input logic mis);
    check_val({tag, ".pc_sel"}, 32'(bus.resp_pc_sel), 32'(pc_sel));
    check_val({tag, ".target"}, bus.resp_target, target);
    check_val({tag, ".link"}, bus.resp_link, link);
    check_val({tag, ".mispredict"}, 32'(bus.resp_mispredict), 32'(mp));
    check_val({tag, ".illegal"}, 32'(bus.resp_illegal), 32'(ill));
    check_val({tag, ".misalign"}, 32'(bus.resp_misalign), 32'(mis));
    @(posedge clk);
    #1;
    check_val({tag, ".released"}, 32'(bus.resp_valid), 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    bus.req_valid      = 1'b0;
    bus.req_kind       = 2'd0;
    bus.req_funct3     = 3'd0;
    bus.req_pc         = '0;
    bus.req_imm        = '0;
    bus.req_rs1        = '0;
    bus.req_rs2        = '0;
    bus.req_pred_taken = 1'b0;
    bus.resp_ready     = 1'b1;

    repeat (2) @(posedge clk);
    #1;
    check_val("rst.req_ready", 32'(bus.req_ready), 32'd1);
    check_val("rst.resp_valid", 32'(bus.resp_valid), 32'd0);
    check_val("rst.pc_sel", 32'(bus.resp_pc_sel), 32'd0);
    check_val("rst.target", bus.resp_target, 32'd0);
    check_val("rst.rs1_data", rs1_data, 32'd0);
    check_val("rst.br_un", 32'(br_un), 32'd0);
    rst = 1'b0;

    send(2'd0, F3_BEQ, 32'h100, 32'h20, 32'h10, 32'h10, 1'b0);
    expect_resp("beq", 1'b1, 32'h120, 32'h104, 1'b1, 1'b0, 1'b0);

    send(2'd0, F3_BLTU, 32'h200, 32'hFFFF_FFF0, 32'h6, 32'hFFFF_FFF5, 1'b1);
    check_val("bltu.br_un", 32'(eval_br_un), 32'd1);
    expect_resp("bltu", 1'b1, 32'h1F0, 32'h204, 1'b0, 1'b0, 1'b0);

    // Not-taken with a misaligned target must not flag misalign
    send(2'd0, F3_BLT, 32'h200, 32'h2, 32'h6, 32'hFFFF_FFF5, 1'b1);
    check_val("blt.br_un", 32'(eval_br_un), 32'd0);
    expect_resp("blt", 1'b0, 32'h202, 32'h204, 1'b1, 1'b0, 1'b0);

    send(2'd2, F3_BEQ, 32'h300, 32'h4, 32'h1003, 32'h0, 1'b1);
    expect_resp("jalr", 1'b0, 32'h1006, 32'h304, 1'b1, 1'b0, 1'b1);

    send(2'd0, 3'b010, 32'h500, 32'h8, 32'h1, 32'h1, 1'b1);
    expect_resp("f3_010", 1'b0, 32'h508, 32'h504, 1'b0, 1'b1, 1'b0);

    send(2'd3, F3_BEQ, 32'h600, 32'h8, 32'h1, 32'h1, 1'b0);
    expect_resp("kind3", 1'b0, 32'h608, 32'h604, 1'b0, 1'b1, 1'b0);

    send(2'd1, F3_BEQ, 32'hFFFF_FFFC, 32'h8, 32'h0, 32'h0, 1'b1);
    expect_resp("jal_wrap", 1'b1, 32'h4, 32'h0, 1'b0, 1'b0, 1'b0);

    send(2'd0, F3_BNE, 32'h700, 32'h40, 32'h1, 32'h2, 1'b1);
    expect_resp("bne", 1'b1, 32'h740, 32'h704, 1'b0, 1'b0, 1'b0);

    send(2'd0, F3_BGEU, 32'h700, 32'h40, 32'h5, 32'h5, 1'b0);
    expect_resp("bgeu", 1'b1, 32'h740, 32'h704, 1'b1, 1'b0, 1'b0);

    send(2'd0, F3_BGE, 32'h700, 32'h40, 32'hFFFF_FFFF, 32'h1, 1'b0);
    expect_resp("bge", 1'b0, 32'h740, 32'h704, 1'b0, 1'b0, 1'b0);

    // Back-pressure: response must hold while resp_ready is low
    bus.resp_ready = 1'b0;
    send(2'd1, F3_BEQ, 32'h800, 32'h10, 32'h0, 32'h0, 1'b0);
    for (int i = 0; i < 5; i++) begin
      @(posedge clk);
      #1;
      check_val("hold.resp_valid", 32'(bus.resp_valid), 32'd1);
      check_val("hold.req_ready", 32'(bus.req_ready), 32'd0);
      check_val("hold.target", bus.resp_target, 32'h810);
      check_val("hold.pc_sel", 32'(bus.resp_pc_sel), 32'd1);
    end
    @(negedge clk);
    bus.resp_ready = 1'b1;
    @(posedge clk);
    #1;
    check_val("hold.release_valid", 32'(bus.resp_valid), 32'd0);
    check_val("hold.release_ready", 32'(bus.req_ready), 32'd1);

    // Reset while in EVAL discards the request
    launch(2'd1, F3_BEQ, 32'h900, 32'h10, 32'h0, 32'h0, 1'b0);
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    check_val("rst_eval.resp_valid", 32'(bus.resp_valid), 32'd0);
    check_val("rst_eval.req_ready", 32'(bus.req_ready), 32'd1);
    @(posedge clk);
    #1;
    check_val("rst_eval.discarded", 32'(bus.resp_valid), 32'd0);
    check_val("rst_eval.pc_sel", 32'(bus.resp_pc_sel), 32'd0);
    $display("[TB] txn reset during EVAL -> resp_valid=%0d req_ready=%0d", bus.resp_valid, bus.req_ready);

`ifdef BRU_PERF_CNT_EN
    force dut.perf_mispred_q = 32'hFFFF_FFFF;
    @(posedge clk);
    #1;
    release dut.perf_mispred_q;
    send(2'd0, F3_BEQ, 32'h100, 32'h20, 32'h3, 32'h3, 1'b0);
    expect_resp("perf_sat", 1'b1, 32'h120, 32'h104, 1'b1, 1'b0, 1'b0);
    check_val("perf_mispred.sat", perf_mispred, 32'hFFFF_FFFF);

    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check_val("perf.cleared", perf_branches, 32'd0);
    for (int i = 0; i < 10; i++) begin
      send(2'd0, (i < 4) ? F3_BEQ : F3_BNE, 32'h400, 32'h10, 32'h7, 32'h7, 1'b0);
      expect_resp("perf_br", (i < 4), 32'h410, 32'h404, (i < 4), 1'b0, 1'b0);
    end
    check_val("perf_branches", perf_branches, 32'd10);
    check_val("perf_taken", perf_taken, 32'd4);
    check_val("perf_mispred", perf_mispred, 32'd4);
`else
    check_val("perf_branches.tied", perf_branches, 32'd0);
    check_val("perf_taken.tied", perf_taken, 32'd0);
    check_val("perf_mispred.tied", perf_mispred, 32'd0);
`endif

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule

// File: doc/branch_unit.md
Name: branch_unit

Overview:
- Initiator side of the branch-comparator interface: launches each branch/jump request's operands and br_un to the existing combinational comparator (BRC), then samples br_less/br_equal back.
- Resolves the branch condition from funct3, computes target and link addresses, and flags mispredicts against the front-end prediction.
- Sits between decode and PC-select; uses a valid/ready handshake on both sides with one registered evaluation cycle.

Parameters:
- XLEN, 32, data/address width
- RESET_PC_SEL, 0, reset value of resp_pc_sel

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous reset, active-high
- req_valid  in  1  request present
- req_ready  out  1  unit can accept
- req_kind  in  2  0=branch, 1=jal, 2=jalr, 3=reserved
- req_funct3  in  3  branch condition
- req_pc  in  XLEN  instruction PC
- req_imm  in  XLEN  sign-extended offset
- req_rs1  in  XLEN  rs1 value
- req_rs2  in  XLEN  rs2 value
- req_pred_taken  in  1  front-end prediction
- rs1_data  out  XLEN  to BRC
- rs2_data  out  XLEN  to BRC
- br_un  out  1  to BRC, unsigned compare
- br_less  in  1  from BRC
- br_equal  in  1  from BRC
- resp_valid  out  1  result present
- resp_ready  in  1  consumer accepts
- resp_pc_sel  out  1  1=redirect to resp_target
- resp_target  out  XLEN  redirect address
- resp_link  out  XLEN  pc+4
- resp_mispredict  out  1  taken differs from req_pred_taken
- resp_illegal  out  1  bad funct3 or kind
- resp_misalign  out  1  taken target[1:0] != 0
- perf_branches, perf_taken, perf_mispred  out  32 each  statistics

Behaviour:
- Clock and reset: one clock `clk`. Reset `rst` is synchronous and active-high.
- FSM states: IDLE, EVAL, RESP. Reset enters IDLE.
- Reset values: all response outputs 0 (resp_pc_sel=RESET_PC_SEL); rs1_data, rs2_data and br_un registers 0; req_ready=1.
- req_ready is 1 only in IDLE.
- IDLE: on req_valid&&req_ready, latch all req_* fields and go to EVAL.
- BRC drive: rs1_data/rs2_data/br_un come straight from the latched registers, so BRC sees stable operands for the whole EVAL cycle.
- br_un = latched funct3[1] for branches, 0 otherwise.
- EVAL: sample br_less/br_equal, compute the result into the response registers, go to RESP. Request-to-resp_valid latency is 2 cycles.
- Taken rule by funct3:
  - 000 BEQ: equal
  - 001 BNE: !equal
  - 100 BLT / 110 BLTU: less
  - 101 BGE / 111 BGEU: !less
  - 010 / 011: illegal=1, taken=0
- jal and jalr are always taken. kind=3: illegal=1, taken=0.
- Target: branch/jal = pc+imm; jalr = (rs1+imm) & ~1. All arithmetic mod 2^XLEN; wrap-around is silent.
- link = pc+4 (wraps at 0xFFFFFFFC -> 0).
- Misalign: taken && target[1:0]!=0 gives misalign=1 and forces pc_sel=0. A not-taken branch never raises misalign.
- pc_sel = taken && !misalign.
- mispredict = (pc_sel != pred_taken); forced 0 when illegal.
- RESP: outputs hold stable while resp_valid=1 && !resp_ready. On resp_ready, go to IDLE. No new request is accepted in the same cycle (max throughput 1 per 3 cycles).
- Reset mid-operation: any state returns to IDLE next edge, resp_valid drops, the latched request is discarded.
- BRC flags are ignored outside EVAL.

Optional Feature:
- BRU_PERF_CNT_EN defined: three 32-bit saturating counters, each incremented on the RESP handshake:
  - perf_branches: kind=0 and not illegal
  - perf_taken: pc_sel=1
  - perf_mispred: mispredict=1
  - All cleared by rst; they hold at 0xFFFFFFFF.
- BRU_PERF_CNT_EN undefined: counters not built, perf_* ports tied to 0.

Decomposition:
- Package branch_pkg:
  - funct3 localparams F3_BEQ..F3_BGEU
  - req_kind enum KIND_BR/KIND_JAL/KIND_JALR
  - FSM state enum
- Sub-module branch_cond: combinational funct3+flags -> {taken, illegal}, instantiated once.
- BRC stays external; branch_unit connects to it at top level.

Test Plan:
- BEQ, rs1=rs2=0x10, pc=0x100, imm=0x20, pred=0 -> resp_valid 2 cycles after accept; pc_sel=1, target=0x120, link=0x104, mispredict=1.
- BLTU, rs1=0x6, rs2=0xFFFFFFF5 -> br_un=1 during EVAL, pc_sel=1. Same operands with BLT -> pc_sel=0.
- JALR, rs1=0x1003, imm=0x4 -> target=0x1006, misalign=1, pc_sel=0.
- funct3=010 with pred=1 -> illegal=1, pc_sel=0, mispredict=0.
- resp_ready held low 5 cycles -> outputs stable, req_ready=0. rst asserted in EVAL -> IDLE next cycle, resp_valid=0.
- With BRU_PERF_CNT_EN: perf_mispred preloaded via force to 0xFFFFFFFF, then a mispredict -> stays 0xFFFFFFFF. 10 branches (4 taken) -> perf_branches=10, perf_taken=4.
